// File: rtl/pc_next_unit_if.sv
// Bus between branch resolution / fetch logic and the PC unit.
// The master drives the resolved select and operands; the slave returns PC state.
interface pc_next_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic [1:0]       pcsrc;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  jalr_base;
   logic             stall;
   logic             halt_req;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_plus4;
   logic             fetch_en;
   logic             halted;
   logic             misalign_fault;
   logic [XLEN-1:0]  fault_pc;
   logic [XLEN-1:0]  fault_target;
   logic [CNT_W-1:0] retired_cnt;

   modport master (
      output pcsrc, imm, jalr_base, stall, halt_req,
      input  pc, pc_plus4, fetch_en, halted, misalign_fault,
             fault_pc, fault_target, retired_cnt
   );

   modport slave (
      input  pcsrc, imm, jalr_base, stall, halt_req,
      output pc, pc_plus4, fetch_en, halted, misalign_fault,
             fault_pc, fault_target, retired_cnt
   );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC generator with boot/run/halt/fault control
// and a retired-instruction counter.
module pc_next_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              CNT_W    = 32
) (
   input logic                clk,
   input logic                rst,
   pc_next_unit_if.slave      bus_io
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t           state_q;
   logic [XLEN-1:0]  pc_q;
   logic             fetch_en_q;
   logic             halted_q;
   logic             fault_q;
   logic [XLEN-1:0]  fault_pc_q;
   logic [XLEN-1:0]  fault_target_q;
   logic [CNT_W-1:0] retired_cnt_q;

   logic [XLEN-1:0]  pc_plus4_d;
   logic [XLEN-1:0]  target_d;
   logic             misalign_d;
   logic             unused_jalr_lsb;

   assign pc_plus4_d      = pc_q + XLEN'(4);
   assign unused_jalr_lsb = bus_io.jalr_base[0];

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      target_d = pc_q;
      case (bus_io.pcsrc)
         2'b00:   target_d = pc_plus4_d;
         2'b01:   target_d = pc_q + bus_io.imm;
         2'b10:   target_d = {bus_io.jalr_base[XLEN-1:1], 1'b0};
         default: target_d = pc_q;
      endcase
      misalign_d = target_d[1] && (bus_io.pcsrc == 2'b01 || bus_io.pcsrc == 2'b10);
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_BOOT;
         pc_q           <= RESET_PC;
         fetch_en_q     <= 1'b0;
         halted_q       <= 1'b0;
         fault_q        <= 1'b0;
         fault_pc_q     <= '0;
         fault_target_q <= '0;
         retired_cnt_q  <= '0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_q    <= ST_RUN;
               fetch_en_q <= 1'b1;
            end
            ST_RUN: begin
               // halt outranks both stall and a pending misalignment fault
               if (bus_io.halt_req) begin
                  state_q    <= ST_HALT;
                  fetch_en_q <= 1'b0;
                  halted_q   <= 1'b1;
               end else if (!bus_io.stall) begin
                  if (misalign_d) begin
                     state_q        <= ST_FAULT;
                     fetch_en_q     <= 1'b0;
                     fault_q        <= 1'b1;
                     fault_pc_q     <= pc_q;
                     fault_target_q <= target_d;
                  end else begin
                     pc_q          <= target_d;
                     retired_cnt_q <= retired_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_io.pc             = pc_q;
   assign bus_io.pc_plus4       = pc_plus4_d;
   assign bus_io.fetch_en       = fetch_en_q;
   assign bus_io.halted         = halted_q;
   assign bus_io.misalign_fault = fault_q;
   assign bus_io.fault_pc       = fault_pc_q;
   assign bus_io.fault_target   = fault_target_q;
   assign bus_io.retired_cnt    = retired_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a reference model pushes expected state
// to a scoreboard each cycle, popped and compared on the falling edge.
module tb_pc_next_unit;

   localparam int          XLEN  = 32;
   localparam int          CNT_W = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   typedef enum {M_BOOT, M_RUN, M_HALT, M_FAULT} mstate_t;

   typedef struct {
      logic [31:0] pc;
      logic        fetch_en;
      logic        halted;
      logic        fault;
      logic [31:0] fpc;
      logic [31:0] ft;
      logic [3:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb_q[$];

   mstate_t     m_state;
   logic [31:0] m_pc, m_fpc, m_ft;
   logic [3:0]  m_cnt;

   always #5 clk = ~clk;

   pc_next_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   pc_next_unit #(.XLEN(XLEN), .RESET_PC(RPC), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.pc       = m_pc;
      e.fetch_en = (m_state == M_RUN);
      e.halted   = (m_state == M_HALT);
      e.fault    = (m_state == M_FAULT);
      e.fpc      = m_fpc;
      e.ft       = m_ft;
      e.cnt      = m_cnt;
      sb_q.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      e = sb_q.pop_front();
      chk({tag, ".pc"},       bus.pc,             e.pc);
      chk({tag, ".pc_plus4"}, bus.pc_plus4,       e.pc + 32'd4);
      chk({tag, ".fetch_en"}, 32'(bus.fetch_en),  32'(e.fetch_en));
      chk({tag, ".halted"},   32'(bus.halted),    32'(e.halted));
      chk({tag, ".fault"},    32'(bus.misalign_fault), 32'(e.fault));
      chk({tag, ".fault_pc"}, bus.fault_pc,       e.fpc);
      chk({tag, ".fault_tg"}, bus.fault_target,   e.ft);
      chk({tag, ".cnt"},      32'(bus.retired_cnt), 32'(e.cnt));
   endtask

   task automatic model_reset();
      m_state = M_BOOT;
      m_pc    = RPC;
      m_cnt   = '0;
      m_fpc   = '0;
      m_ft    = '0;
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model, check at the next falling edge.
   task automatic step(input string tag, input logic [1:0] sel, input logic [31:0] imm,
                       input logic [31:0] jb, input logic stl, input logic hlt);
      logic [31:0] t;
      bus.pcsrc     = sel;
      bus.imm       = imm;
      bus.jalr_base = jb;
      bus.stall     = stl;
      bus.halt_req  = hlt;
      case (m_state)
         M_BOOT: m_state = M_RUN;
         M_RUN: begin
            if (hlt) m_state = M_HALT;
            else if (!stl) begin
               case (sel)
                  2'b00:   t = m_pc + 32'd4;
                  2'b01:   t = m_pc + imm;
                  2'b10:   t = jb & 32'hFFFF_FFFE;
                  default: t = m_pc;
               endcase
               if (t[1] && (sel == 2'b01 || sel == 2'b10)) begin
                  m_fpc   = m_pc;
                  m_ft    = t;
                  m_state = M_FAULT;
               end else begin
                  m_pc  = t;
                  m_cnt = m_cnt + 4'd1;
               end
            end
         end
         default: ;
      endcase
      push_exp();
      @(negedge clk);
      check_out(tag);
   endtask

   // Called at a falling edge: asserts reset asynchronously, checks it took effect before any clock edge, then boots.
   task automatic apply_reset(input string tag);
      #2;
      rst           = 1'b1;
      bus.pcsrc     = 2'b00;
      bus.imm       = '0;
      bus.jalr_base = '0;
      bus.stall     = 1'b0;
      bus.halt_req  = 1'b0;
      model_reset();
      #1;
      push_exp();
      check_out({tag, ".rst"});
      @(negedge clk);
      rst = 1'b0;
      push_exp();
      check_out({tag, ".boot"});
      step({tag, ".boot_exit"}, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.pcsrc     = 2'b00;
      bus.imm       = '0;
      bus.jalr_base = '0;
      bus.stall     = 1'b0;
      bus.halt_req  = 1'b0;
      @(negedge clk);

      // Boot and sequential fetch
      apply_reset("boot");
      chk("boot.lit_pc", bus.pc, 32'h100);
      for (int i = 0; i < 3; i++) step("seq", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("seq.lit_pc", bus.pc, 32'h10C);
      chk("seq.lit_cnt", 32'(bus.retired_cnt), 32'd3);

      // Branch and JALR
      step("jalr200", 2'b10, 32'h0, 32'h200, 1'b0, 1'b0);
      step("br_m8", 2'b01, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
      chk("br_m8.lit_pc", bus.pc, 32'h1F8);
      step("jalr301", 2'b10, 32'h0, 32'h301, 1'b0, 1'b0);
      chk("jalr301.lit_pc", bus.pc, 32'h300);

      // Stall, release, hold
      for (int i = 0; i < 4; i++) step("stall", 2'b01, 32'h10, 32'h0, 1'b1, 1'b0);
      step("release", 2'b01, 32'h10, 32'h0, 1'b0, 1'b0);
      step("hold", 2'b11, 32'h10, 32'h0, 1'b0, 1'b0);
      chk("hold.lit_pc", bus.pc, 32'h310);
      chk("hold.lit_cnt", 32'(bus.retired_cnt), 32'd8);

      // PC wrap and counter wrap
      step("jalr_top", 2'b10, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
      step("pc_wrap", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("pc_wrap.lit_pc", bus.pc, 32'h0);
      for (int i = 0; i < 5; i++) step("to15", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("to15.lit_cnt", 32'(bus.retired_cnt), 32'd15);
      step("cnt_wrap", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("cnt_wrap.lit_cnt", 32'(bus.retired_cnt), 32'd0);

      // Misaligned branch target, then inputs ignored
      step("jalr40", 2'b10, 32'h0, 32'h40, 1'b0, 1'b0);
      step("misalign", 2'b01, 32'h6, 32'h0, 1'b0, 1'b0);
      chk("misalign.lit_ft", bus.fault_target, 32'h46);
      chk("misalign.lit_fpc", bus.fault_pc, 32'h40);
      step("flt_ign0", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      step("flt_ign1", 2'b10, 32'h0, 32'h80, 1'b0, 1'b0);
      step("flt_ign2", 2'b01, 32'h4, 32'h0, 1'b0, 1'b1);

      // Halt beats stall and a misaligned target in the same cycle
      apply_reset("r2");
      step("halt_prio", 2'b01, 32'h6, 32'h0, 1'b1, 1'b1);
      chk("halt_prio.lit_halted", 32'(bus.halted), 32'd1);
      chk("halt_prio.lit_fault", 32'(bus.misalign_fault), 32'd0);
      step("halt_ign0", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      step("halt_ign1", 2'b10, 32'h0, 32'h400, 1'b0, 1'b0);

      // Async reset mid-HALT, then a misaligned JALR target
      apply_reset("r3");
      step("jalr_mis", 2'b10, 32'h0, 32'h103, 1'b0, 1'b0);
      chk("jalr_mis.lit_ft", bus.fault_target, 32'h102);
      step("jalr_ign", 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
